mem_port_arbiter: RTL and testbench

- Shares the single-port unified 16-bit memory between the PMIPS instruction-fetch stage and the MEM stage (lw/sw).
- Sequences each multi-cycle memory access and returns a one-cycle acknowledge to the winning requester.
- Sits between the pipeline (IF stage, EX/MEM register) and the RAM; the pipeline controller uses the stall outputs to freeze the PC and insert bubbles.

---
 rtl/pmips_pkg.sv | 17 +
 rtl/mem_lat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pmips_pkg.sv
// Shared PMIPS definitions: memory-arbiter state encoding, grant identifiers
// and default bus widths.
package pmips_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DACC  = 2'd2
  } state_t;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter timing one RAM access; o_last marks the final
// ram_en cycle.
module mem_lat_counter #(
  parameter int LAT_W = 4
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [LAT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-port RAM between instruction fetch and the
// MEM stage, sequencing each multi-cycle access and pulsing a one-cycle ack.
module mem_port_arbiter
  import pmips_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2,
  parameter int LAT_W   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              if_stall,
  output logic              d_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic              r_last_grant;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic              w_if_want;
  logic              w_d_want;
  logic              w_gnt_f;
  logic              w_gnt_d;
  logic              w_last;

  // A requester still seeing its ack has already been served this round.
  assign w_if_want = if_req & ~r_if_ack;
  assign w_d_want  = d_req & ~r_d_ack;

  mem_lat_counter #(
    .LAT_W (LAT_W)
  ) u_lat_cnt (
    .i_clock    (clock),
    .i_reset_n  (reset),
    .i_load     (w_gnt_f | w_gnt_d),
    .i_load_val (LAT_W'(MEM_LAT)),
    .i_dec      (r_state != IDLE),
    .o_last     (w_last)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Data normally wins; fetch wins a tie right after a data grant.
  always_comb begin
    w_next  = r_state;
    w_gnt_f = 1'b0;
    w_gnt_d = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_want && (!w_if_want || (r_last_grant != GNT_DATA))) begin
          w_gnt_d = 1'b1;
          w_next  = DACC;
        end else if (w_if_want) begin
          w_gnt_f = 1'b1;
          w_next  = FETCH;
        end
      end
      FETCH, DACC: begin
        if (w_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_last_grant <= GNT_FETCH;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_gnt_d) begin
        r_ram_en     <= 1'b1;
        r_ram_we     <= d_we;
        r_ram_addr   <= d_addr;
        r_ram_wdata  <= d_wdata;
        r_last_grant <= GNT_DATA;
      end else if (w_gnt_f) begin
        r_ram_en     <= 1'b1;
        r_ram_we     <= 1'b0;
        r_ram_addr   <= if_addr;
        r_last_grant <= GNT_FETCH;
      end else if ((r_state != IDLE) && w_last) begin
        r_ram_en <= 1'b0;
        r_ram_we <= 1'b0;
        if (r_state == FETCH) begin
          r_if_rdata <= ram_rdata;
          r_if_ack   <= 1'b1;
        end else begin
          r_d_ack <= 1'b1;
          if (!r_ram_we) begin
            r_d_rdata <= ram_rdata;
          end
        end
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_stall  = if_req & ~r_if_ack;
  assign d_stall   = d_req & ~r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a MEM_LAT=2 instance with a RAM model
// plus a MEM_LAT=1 instance for single-cycle back-to-back traffic.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [15:0] if_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic        if_ack, d_ack, if_stall, d_stall, ram_en, ram_we;

  logic        b_if_req = 1'b0, b_d_req = 1'b0;
  logic [15:0] b_if_addr = 16'h0040, b_d_addr = 16'h0030;
  logic [15:0] b_if_rdata, b_d_rdata, b_ram_addr, b_ram_wdata, b_ram_rdata;
  logic        b_if_ack, b_d_ack, b_if_stall, b_d_stall, b_ram_en, b_ram_we;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          en_cnt = 0;
  logic [15:0] last_d = '0;
  logic [15:0] st_val = '0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .LAT_W(4)) u_dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .if_stall(if_stall), .d_stall(d_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .LAT_W(4)) u_dut1 (
    .clock(clock), .reset(reset),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
    .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata(16'h0000),
    .d_rdata(b_d_rdata), .d_ack(b_d_ack), .if_stall(b_if_stall), .d_stall(b_d_stall),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // RAM contents: two fixed words, the last stored word at 0x0020, otherwise a hash.
  always_comb begin
    case (ram_addr)
      16'h0004: ram_rdata = 16'h6A81;
      16'h0010: ram_rdata = 16'h1234;
      16'h0020: ram_rdata = st_val;
      default:  ram_rdata = ram_addr ^ 16'hA5A5;
    endcase
  end
  always @(posedge clock) if (ram_en && ram_we && ram_addr == 16'h0020) st_val <= ram_wdata;
  assign b_ram_rdata = b_ram_addr ^ 16'h5A5A;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: RAM bus against the in-flight entry, ack contents and order.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      en_cnt = 0;
    end else begin
      chk("if_stall", if_stall, if_req & ~if_ack);
      chk("d_stall", d_stall, d_req & ~d_ack);
      if (ram_en) begin
        if (q.size() == 0) begin
          chk("unexpected_ram_en", ram_en, 1'b0);
        end else begin
          chk("ram_addr", ram_addr, q[0].addr);
          chk("ram_we", ram_we, q[0].we);
          if (q[0].we) chk("ram_wdata", ram_wdata, q[0].wdata);
        end
        en_cnt++;
      end
      if (if_ack || d_ack) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", {if_ack, d_ack}, 2'b00);
        end else begin
          e = q.pop_front();
          chk("ack_kind", {if_ack, d_ack}, e.is_d ? 2'b01 : 2'b10);
          chk(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
          chk("ram_en_cycles", en_cnt, MEM_LAT);
        end
        en_cnt = 0;
      end
    end
  end

  task automatic wait_ack(input bit want_d, output int at_cyc);
    int n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!(want_d ? d_ack : if_ack) && n < 64);
    at_cyc = cyc;
    if (!(want_d ? d_ack : if_ack)) chk("ack_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    b_if_req = 1'b0; b_d_req = 1'b0;
    q.delete();
    last_d = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ctrl", {ram_en, ram_we, if_ack, d_ack, if_stall, d_stall}, '0);
    chk("rst_bus", {ram_addr, ram_wdata}, '0);
    chk("rst_rdata", {if_rdata, d_rdata}, '0);
    chk("rst_dut1", {b_ram_en, b_ram_we, b_if_ack, b_d_ack, b_ram_addr, b_if_rdata, b_d_rdata}, '0);
    reset = 1'b1;
  endtask

  initial begin
    int t0, t1, k, n, lastf, last1, en1;

    // Fetch only: ack MEM_LAT+1 cycles after the request is raised.
    do_reset();
    q.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h6A81});
    if_addr = 16'h0004; if_req = 1'b1; t0 = cyc;
    wait_ack(1'b0, t1);
    if_req = 1'b0;
    chk("fetch_latency", t1 - t0, MEM_LAT + 1);

    // Simultaneous requests after reset: data first, fetch granted in the d_ack cycle.
    do_reset();
    q.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234});
    q.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h6A81});
    d_addr = 16'h0010; d_we = 1'b0; d_req = 1'b1;
    if_addr = 16'h0004; if_req = 1'b1;
    wait_ack(1'b1, t0);
    d_req = 1'b0;
    wait_ack(1'b0, t1);
    if_req = 1'b0;
    chk("fetch_after_data", t1 - t0, MEM_LAT + 1);
    last_d = 16'h1234;

    // Fairness: both held, grants alternate D,F,D,F,D,F.
    for (int i = 0; i < 3; i++) begin
      q.push_back('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h1234});
      q.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h6A81});
    end
    d_req = 1'b1; if_req = 1'b1;
    k = 0; n = 0; lastf = -1;
    do begin
      @(posedge clock); #1; n++;
      if (if_ack) begin
        if (lastf >= 0) chk("fetch_gap_bound", (cyc - lastf) <= 2 * (MEM_LAT + 1), 1'b1);
        lastf = cyc;
      end
      if (if_ack || d_ack) k++;
    end while (k < 6 && n < 100);
    d_req = 1'b0; if_req = 1'b0;
    chk("fairness_acks", k, 6);

    // Store leaves d_rdata untouched; a following load reads the stored word back.
    q.push_back('{1'b1, 1'b1, 16'h0020, 16'hBEEF, last_d});
    d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'hBEEF; d_req = 1'b1;
    wait_ack(1'b1, t0);
    d_req = 1'b0; d_we = 1'b0;
    chk("store_mem", st_val, 16'hBEEF);
    q.push_back('{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hBEEF});
    d_req = 1'b1;
    wait_ack(1'b1, t0);
    d_req = 1'b0;

    // Reset during the first ram_en cycle of a fetch aborts it without an ack.
    q.push_back('{1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0008 ^ 16'hA5A5});
    if_addr = 16'h0008; if_req = 1'b1; n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!ram_en && n < 16);
    chk("abort_saw_ram_en", ram_en, 1'b1);
    reset = 1'b0; if_req = 1'b0; q.delete(); last_d = '0;
    @(posedge clock); #1;
    chk("abort_ctrl", {ram_en, ram_we, if_ack, d_ack}, '0);
    chk("abort_data", {ram_addr, ram_wdata, if_rdata, d_rdata}, '0);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      chk("abort_no_ack", if_ack, 1'b0);
    end
    q.push_back('{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h6A81});
    if_addr = 16'h0004; if_req = 1'b1; t0 = cyc;
    wait_ack(1'b0, t1);
    if_req = 1'b0;
    chk("post_reset_latency", t1 - t0, MEM_LAT + 1);

    // MEM_LAT=1: alternating traffic gives an ack every 2 cycles, one ram_en cycle each.
    b_if_req = 1'b1; b_d_req = 1'b1;
    k = 0; n = 0; last1 = -1; en1 = 0;
    do begin
      @(posedge clock); #1; n++;
      if (b_ram_en) en1++;
      if (b_if_ack || b_d_ack) begin
        chk("lat1_en_cycles", en1, 1);
        chk("lat1_rdata", b_if_ack ? b_if_rdata : b_d_rdata,
            b_if_ack ? (16'h0040 ^ 16'h5A5A) : (16'h0030 ^ 16'h5A5A));
        if (last1 >= 0) chk("lat1_ack_gap", cyc - last1, 2);
        last1 = cyc;
        en1 = 0;
        k++;
      end
    end while (k < 6 && n < 60);
    b_if_req = 1'b0; b_d_req = 1'b0;
    chk("lat1_acks", k, 6);

    repeat (3) @(posedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
